// File: rtl/modulo_batalha_naval_pkg.sv
// Shared game-state encoding and board cell-index helper for the battleship block.
package modulo_batalha_naval_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ATTACK = 2'b01;
  localparam logic [1:0] ST_WON    = 2'b10;
  localparam logic [1:0] ST_LOST   = 2'b11;

  // Flat bit position of board cell (r,c) in a row-major map
  function automatic int unsigned cell_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/modulo_varredura_colunas.sv
// Free-running LED-matrix column scanner: counter plus registered one-hot select.
module modulo_varredura_colunas #(
  parameter  int unsigned COLS = 5,
  localparam int unsigned CW   = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            scan_tick,
  output logic [CW-1:0]   col_nxt_c,
  output logic [COLS-1:0] m_col
);

  logic [CW-1:0] cnt;

  // Next column: step on scan_tick, wrapping after the last column
  always_comb begin
    col_nxt_c = cnt;
    if (scan_tick) begin
      col_nxt_c = (cnt == CW'(COLS - 1)) ? '0 : cnt + CW'(1);
    end
  end

  // Counter and one-hot select update together so they never disagree
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt   <= '0;
      m_col <= COLS'(1);
    end else begin
      cnt   <= col_nxt_c;
      m_col <= COLS'(1) << col_nxt_c;
    end
  end

endmodule

// File: rtl/modulo_batalha_naval_param.sv
// Parameterised battleship game: map load, attack scoring, win/lose FSM and LED scan.
module modulo_batalha_naval_param
  import modulo_batalha_naval_pkg::*;
#(
  parameter  int unsigned ROWS  = 7,
  parameter  int unsigned COLS  = 5,
  parameter  int unsigned SHOTS = 12,
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned HW    = $clog2(N + 1),
  localparam int unsigned SW    = $clog2(SHOTS + 1)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    ship_map,
  input  logic            load_map,
  input  logic [3:0]      at_row,
  input  logic [3:0]      at_col,
  input  logic            at_confirm,
  input  logic            scan_tick,
  output logic [COLS-1:0] m_col,
  output logic [ROWS-1:0] m_line,
  output logic            rgb_r,
  output logic            rgb_g,
  output logic [HW-1:0]   hits,
  output logic [SW-1:0]   shots_left,
  output logic [1:0]      state
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(COLS);

  logic [N-1:0]    map_q, map_d;
  logic [N-1:0]    att_q, att_d;
  logic [HW-1:0]   ship_cnt_q, ship_cnt_d;
  logic [HW-1:0]   hits_d;
  logic [SW-1:0]   shots_d;
  logic [1:0]      state_d;
  logic            rgb_r_d, rgb_g_d;
  logic [ROWS-1:0] m_line_d;
  logic [HW-1:0]   pop_c;
  logic            oor_c;
  logic [IW-1:0]   at_idx_c;
  logic [CW-1:0]   col_nxt_c;

  modulo_varredura_colunas #(.COLS(COLS)) u_scan (
    .clk       (clk),
    .clr       (clr),
    .scan_tick (scan_tick),
    .col_nxt_c (col_nxt_c),
    .m_col     (m_col)
  );

  // Ship count of the incoming map, latched only at load
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop_c = pop_c + HW'(ship_map[i]);
    end
  end

  // Attack decode: range check and flat cell index
  always_comb begin
    oor_c    = ({1'b0, at_row} >= 5'(ROWS)) || ({1'b0, at_col} >= 5'(COLS));
    at_idx_c = IW'(cell_idx(32'(at_row), 32'(at_col), COLS));
  end

  // Next-state and game bookkeeping; load_map outranks any attack
  always_comb begin
    map_d      = map_q;
    att_d      = att_q;
    ship_cnt_d = ship_cnt_q;
    hits_d     = hits;
    shots_d    = shots_left;
    state_d    = state;
    rgb_r_d    = rgb_r;
    rgb_g_d    = rgb_g;
    if (load_map) begin
      map_d      = ship_map;
      att_d      = '0;
      ship_cnt_d = pop_c;
      hits_d     = '0;
      shots_d    = SW'(SHOTS);
      rgb_r_d    = 1'b0;
      rgb_g_d    = 1'b0;
      state_d    = (pop_c == '0) ? ST_WON : ST_ATTACK;
    end else if (state == ST_ATTACK && at_confirm) begin
      if (oor_c) begin
        rgb_r_d = 1'b1;
        rgb_g_d = 1'b1;
      end else if (att_q[at_idx_c]) begin
        rgb_r_d = 1'b0;
        rgb_g_d = 1'b0;
      end else begin
        att_d[at_idx_c] = 1'b1;
        shots_d         = shots_left - SW'(1);
        if (map_q[at_idx_c]) begin
          hits_d  = hits + HW'(1);
          rgb_r_d = 1'b0;
          rgb_g_d = 1'b1;
        end else begin
          rgb_r_d = 1'b1;
          rgb_g_d = 1'b0;
        end
        // A fleet-completing hit wins even when it uses the last shot
        if (hits_d == ship_cnt_q) begin
          state_d = ST_WON;
        end else if (shots_d == '0) begin
          state_d = ST_LOST;
        end
      end
    end
  end

  // Row data for the column being selected next, from next-cycle game state
  always_comb begin
    m_line_d = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      case (state_d)
        ST_ATTACK: m_line_d[r] = att_d[IW'(cell_idx(r, 32'(col_nxt_c), COLS))];
        ST_WON,
        ST_LOST:   m_line_d[r] = map_d[IW'(cell_idx(r, 32'(col_nxt_c), COLS))];
        default:   m_line_d[r] = 1'b0;
      endcase
    end
  end

  // Game registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      map_q      <= '0;
      att_q      <= '0;
      ship_cnt_q <= '0;
      hits       <= '0;
      shots_left <= SW'(SHOTS);
      state      <= ST_IDLE;
      rgb_r      <= 1'b0;
      rgb_g      <= 1'b0;
      m_line     <= '0;
    end else begin
      map_q      <= map_d;
      att_q      <= att_d;
      ship_cnt_q <= ship_cnt_d;
      hits       <= hits_d;
      shots_left <= shots_d;
      state      <= state_d;
      rgb_r      <= rgb_r_d;
      rgb_g      <= rgb_g_d;
      m_line     <= m_line_d;
    end
  end

endmodule

// File: tb/tb_modulo_batalha_naval_param.sv
// Directed self-checking bench for modulo_batalha_naval_param (default and SHOTS=2 builds).
module tb_modulo_batalha_naval_param;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [34:0] ship_map = '0;
  logic        load_map = 1'b0;
  logic [3:0]  at_row = '0;
  logic [3:0]  at_col = '0;
  logic        at_confirm = 1'b0;
  logic        scan_tick = 1'b0;
  logic [4:0]  m_col;
  logic [6:0]  m_line;
  logic        rgb_r, rgb_g;
  logic [5:0]  hits;
  logic [3:0]  shots_left;
  logic [1:0]  state;

  logic [34:0] ship_map2 = '0;
  logic        load_map2 = 1'b0;
  logic [3:0]  at_row2 = '0;
  logic [3:0]  at_col2 = '0;
  logic        at_confirm2 = 1'b0;
  logic [4:0]  m_col2;
  logic [6:0]  m_line2;
  logic        rgb_r2, rgb_g2;
  logic [5:0]  hits2;
  logic [1:0]  shots_left2;
  logic [1:0]  state2;

  int checks = 0;
  int failures = 0;
  int exp_col;

  always #5 clk = ~clk;

  modulo_batalha_naval_param dut (
    .clk(clk), .clr(clr), .ship_map(ship_map), .load_map(load_map),
    .at_row(at_row), .at_col(at_col), .at_confirm(at_confirm), .scan_tick(scan_tick),
    .m_col(m_col), .m_line(m_line), .rgb_r(rgb_r), .rgb_g(rgb_g),
    .hits(hits), .shots_left(shots_left), .state(state)
  );

  modulo_batalha_naval_param #(.ROWS(7), .COLS(5), .SHOTS(2)) dut2 (
    .clk(clk), .clr(clr), .ship_map(ship_map2), .load_map(load_map2),
    .at_row(at_row2), .at_col(at_col2), .at_confirm(at_confirm2), .scan_tick(1'b0),
    .m_col(m_col2), .m_line(m_line2), .rgb_r(rgb_r2), .rgb_g(rgb_g2),
    .hits(hits2), .shots_left(shots_left2), .state(state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [34:0] m);
    ship_map = m; load_map = 1'b1;
    tick();
    load_map = 1'b0;
  endtask

  task automatic attack(input logic [3:0] r, input logic [3:0] c);
    at_row = r; at_col = c; at_confirm = 1'b1;
    tick();
    at_confirm = 1'b0;
  endtask

  task automatic attack2(input logic [3:0] r, input logic [3:0] c);
    at_row2 = r; at_col2 = c; at_confirm2 = 1'b1;
    tick();
    at_confirm2 = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; tick(); tick(); clr = 1'b0;
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state); end
    checks++; if (hits !== 6'd0) begin failures++; $display("FAIL reset_hits got=%0d exp=0", hits); end
    checks++; if (shots_left !== 4'd12) begin failures++; $display("FAIL reset_shots got=%0d exp=12", shots_left); end
    checks++; if ({rgb_r, rgb_g} !== 2'b00) begin failures++; $display("FAIL reset_rgb got=%b exp=00", {rgb_r, rgb_g}); end
    checks++; if (m_col !== 5'b00001) begin failures++; $display("FAIL reset_mcol got=%b exp=00001", m_col); end
    checks++; if (m_line !== 7'd0) begin failures++; $display("FAIL reset_mline got=%b exp=0", m_line); end
    exp_col = 0;
  endtask

  task automatic test_scan();
    logic [4:0] exp_mcol;
    for (int i = 0; i < 5; i++) begin
      scan_tick = 1'b1; tick(); scan_tick = 1'b0;
      exp_col = (exp_col + 1) % 5;
      exp_mcol = 5'b00001 << exp_col;
      checks++; if (m_col !== exp_mcol) begin failures++; $display("FAIL scan_step%0d got=%b exp=%b", i, m_col, exp_mcol); end
      checks++; if (m_line !== 7'd0) begin failures++; $display("FAIL scan_idle_mline%0d got=%b exp=0", i, m_line); end
    end
    // the 4th step lands on the last column, the 5th wraps back to column 0
    checks++; if (m_col !== 5'b00001) begin failures++; $display("FAIL scan_wrap got=%b exp=00001", m_col); end
  endtask

  task automatic test_hit();
    load(35'h41);
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL load_state got=%b exp=01", state); end
    attack(4'd0, 4'd0);
    checks++; if ({rgb_r, rgb_g} !== 2'b01) begin failures++; $display("FAIL hit_rgb got=%b exp=01", {rgb_r, rgb_g}); end
    checks++; if (hits !== 6'd1) begin failures++; $display("FAIL hit_hits got=%0d exp=1", hits); end
    checks++; if (shots_left !== 4'd11) begin failures++; $display("FAIL hit_shots got=%0d exp=11", shots_left); end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL hit_state got=%b exp=01", state); end
    checks++; if (m_line !== 7'b0000001) begin failures++; $display("FAIL hit_mline got=%b exp=0000001", m_line); end
  endtask

  task automatic test_repeat_and_win();
    attack(4'd0, 4'd0);
    checks++; if ({rgb_r, rgb_g} !== 2'b00) begin failures++; $display("FAIL rep_rgb got=%b exp=00", {rgb_r, rgb_g}); end
    checks++; if (shots_left !== 4'd11) begin failures++; $display("FAIL rep_shots got=%0d exp=11", shots_left); end
    attack(4'd1, 4'd1);
    checks++; if (hits !== 6'd2) begin failures++; $display("FAIL win_hits got=%0d exp=2", hits); end
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL win_state got=%b exp=10", state); end
    checks++; if (m_line !== 7'b0000001) begin failures++; $display("FAIL win_mline_c0 got=%b exp=0000001", m_line); end
    scan_tick = 1'b1; tick(); scan_tick = 1'b0; exp_col = 1;
    checks++; if (m_col !== 5'b00010) begin failures++; $display("FAIL win_mcol_c1 got=%b exp=00010", m_col); end
    checks++; if (m_line !== 7'b0000010) begin failures++; $display("FAIL win_mline_c1 got=%b exp=0000010", m_line); end
    attack(4'd2, 4'd2);
    checks++; if (shots_left !== 4'd10 || state !== 2'b10) begin failures++; $display("FAIL won_ignores_attack shots=%0d state=%b exp=10/10", shots_left, state); end
  endtask

  task automatic test_out_of_range();
    load(35'h41);
    attack(4'd7, 4'd0);
    checks++; if ({rgb_r, rgb_g} !== 2'b11) begin failures++; $display("FAIL oor_row_rgb got=%b exp=11", {rgb_r, rgb_g}); end
    checks++; if (shots_left !== 4'd12) begin failures++; $display("FAIL oor_row_shots got=%0d exp=12", shots_left); end
    attack(4'd0, 4'd5);
    checks++; if ({rgb_r, rgb_g} !== 2'b11 || shots_left !== 4'd12) begin failures++; $display("FAIL oor_col rgb=%b shots=%0d exp=11/12", {rgb_r, rgb_g}, shots_left); end
    attack(4'd2, 4'd1);
    checks++; if ({rgb_r, rgb_g} !== 2'b10 || shots_left !== 4'd11) begin failures++; $display("FAIL miss rgb=%b shots=%0d exp=10/11", {rgb_r, rgb_g}, shots_left); end
    // column 1 is selected: row 2 now shows as attacked
    checks++; if (m_line !== 7'b0000100) begin failures++; $display("FAIL miss_mline got=%b exp=0000100", m_line); end
    ship_map = 35'h41; load_map = 1'b1; at_row = 4'd1; at_col = 4'd1; at_confirm = 1'b1;
    tick();
    load_map = 1'b0; at_confirm = 1'b0;
    checks++; if (state !== 2'b01 || hits !== 6'd0 || shots_left !== 4'd12) begin failures++; $display("FAIL load_wins state=%b hits=%0d shots=%0d exp=01/0/12", state, hits, shots_left); end
    checks++; if ({rgb_r, rgb_g} !== 2'b00 || m_line !== 7'd0) begin failures++; $display("FAIL load_wins_rgb rgb=%b mline=%b exp=00/0", {rgb_r, rgb_g}, m_line); end
  endtask

  task automatic test_empty_map();
    load(35'h0);
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL empty_state got=%b exp=10", state); end
    checks++; if (shots_left !== 4'd12) begin failures++; $display("FAIL empty_shots got=%0d exp=12", shots_left); end
  endtask

  task automatic test_lost();
    ship_map2 = 35'h1; load_map2 = 1'b1; tick(); load_map2 = 1'b0;
    checks++; if (state2 !== 2'b01 || shots_left2 !== 2'd2) begin failures++; $display("FAIL s2_load state=%b shots=%0d exp=01/2", state2, shots_left2); end
    attack2(4'd2, 4'd2);
    checks++; if (shots_left2 !== 2'd1 || {rgb_r2, rgb_g2} !== 2'b10) begin failures++; $display("FAIL s2_miss1 shots=%0d rgb=%b exp=1/10", shots_left2, {rgb_r2, rgb_g2}); end
    attack2(4'd3, 4'd3);
    checks++; if (state2 !== 2'b11 || shots_left2 !== 2'd0) begin failures++; $display("FAIL s2_lost state=%b shots=%0d exp=11/0", state2, shots_left2); end
    attack2(4'd0, 4'd0);
    checks++; if (state2 !== 2'b11 || hits2 !== 6'd0 || shots_left2 !== 2'd0 || {rgb_r2, rgb_g2} !== 2'b10) begin failures++; $display("FAIL s2_lost_hold state=%b hits=%0d shots=%0d rgb=%b exp=11/0/0/10", state2, hits2, shots_left2, {rgb_r2, rgb_g2}); end
    checks++; if (m_line2 !== 7'b0000001 || m_col2 !== 5'b00001) begin failures++; $display("FAIL s2_lost_reveal mline=%b mcol=%b exp=0000001/00001", m_line2, m_col2); end
    ship_map2 = 35'h1; load_map2 = 1'b1; tick(); load_map2 = 1'b0;
    attack2(4'd4, 4'd4);
    attack2(4'd0, 4'd0);
    checks++; if (state2 !== 2'b10 || hits2 !== 6'd1 || shots_left2 !== 2'd0) begin failures++; $display("FAIL s2_last_shot_win state=%b hits=%0d shots=%0d exp=10/1/0", state2, hits2, shots_left2); end
  endtask

  task automatic test_clr_midgame();
    load(35'h41);
    attack(4'd0, 4'd0);
    scan_tick = 1'b1; tick(); tick(); scan_tick = 1'b0;
    clr = 1'b1; load_map = 1'b1; at_confirm = 1'b1; scan_tick = 1'b1;
    tick();
    clr = 1'b0; load_map = 1'b0; at_confirm = 1'b0; scan_tick = 1'b0;
    checks++; if (state !== 2'b00 || hits !== 6'd0 || shots_left !== 4'd12) begin failures++; $display("FAIL clr_core state=%b hits=%0d shots=%0d exp=00/0/12", state, hits, shots_left); end
    checks++; if ({rgb_r, rgb_g} !== 2'b00 || m_col !== 5'b00001 || m_line !== 7'd0) begin failures++; $display("FAIL clr_out rgb=%b mcol=%b mline=%b exp=00/00001/0", {rgb_r, rgb_g}, m_col, m_line); end
    attack(4'd1, 4'd1);
    checks++; if (state !== 2'b00 || hits !== 6'd0) begin failures++; $display("FAIL idle_ignores state=%b hits=%0d exp=00/0", state, hits); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hit();
    test_repeat_and_win();
    test_out_of_range();
    test_empty_map();
    test_lost();
    test_clr_midgame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
